// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// codes and a counter-width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } rst_seq_state_e;

    localparam logic [1:0] RST_CAUSE_POR = 2'b01;
    localparam logic [1:0] RST_CAUSE_SW  = 2'b10;
    localparam logic [1:0] RST_CAUSE_WDT = 2'b11;

    // Bits needed for a counter that runs 0 .. n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_n_sync_chain.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES
// rising clock edges.
module rst_n_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n_async,
    output logic rst_n_s
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift ones in from the bottom once the pad reset is released.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_s = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/rst_n_seq_ctrl.sv
// Reset sequencer: synchronises the pad reset, holds all domains in reset for
// HOLD_CYCLES, then releases NUM_CH domains in order, GAP_CYCLES apart.
// Optional watchdog enabled with the RST_SEQ_WDT_EN macro.
module rst_n_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int NUM_CH      = 3,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst_n_async,
    input  logic              sw_rst_req,
`ifdef RST_SEQ_WDT_EN
    input  logic              wdt_kick,
`endif
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              rst_busy,
    output logic [1:0]        rst_cause
);

    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int GAP_W  = cnt_w(GAP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [NUM_CH-1:0] OUT_FIRST = NUM_CH'(1'b1);

    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
        NUM_CH < 1 || WDT_CYCLES < 2) begin : g_param_check
        $error("rst_n_seq_ctrl: illegal parameter value");
    end

    rst_seq_state_e    state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [NUM_CH-1:0] rst_n_out_r;
    logic              rst_busy_r;
    logic [1:0]        rst_cause_r;

    logic              rst_n_s;
    logic [HOLD_W-1:0] hold_inc_s;
    logic [GAP_W-1:0]  gap_inc_s;
    logic [NUM_CH-1:0] out_step_s;
    logic              wdt_expire_s;

    rst_n_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst_n_async (rst_n_async),
        .rst_n_s     (rst_n_s)
    );

    assign hold_inc_s = hold_cnt_r + HOLD_W'(1);
    assign gap_inc_s  = gap_cnt_r + GAP_W'(1);
    // Thermometer step: shift in one more released channel from bit 0 upward.
    assign out_step_s = NUM_CH'({rst_n_out_r, 1'b1});

`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W = cnt_w(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_r;
    logic [WDT_W-1:0] wdt_inc_s;

    assign wdt_inc_s    = wdt_cnt_r + WDT_W'(1);
    assign wdt_expire_s = (state_r == ST_RUN) && !wdt_kick && (wdt_inc_s == WDT_LAST);

    // Watchdog counts only in RUN; it sits at zero elsewhere so RUN entry starts fresh.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            wdt_cnt_r <= '0;
        end else if (state_r != ST_RUN || wdt_kick) begin
            wdt_cnt_r <= '0;
        end else begin
            wdt_cnt_r <= wdt_inc_s;
        end
    end
`else
    assign wdt_expire_s = 1'b0;
`endif

    // Sequencer FSM with registered reset outputs.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            state_r     <= ST_ASSERT;
            hold_cnt_r  <= '0;
            gap_cnt_r   <= '0;
            rst_n_out_r <= '0;
            rst_busy_r  <= 1'b1;
            rst_cause_r <= RST_CAUSE_POR;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    if (!rst_n_s) begin
                        hold_cnt_r <= '0;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r  <= '0;
                        rst_n_out_r <= OUT_FIRST;
                        gap_cnt_r   <= '0;
                        if (NUM_CH == 1) begin
                            state_r    <= ST_RUN;
                            rst_busy_r <= 1'b0;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
                        hold_cnt_r <= hold_inc_s;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r   <= '0;
                        rst_n_out_r <= out_step_s;
                        if (&out_step_s) begin
                            state_r    <= ST_RUN;
                            rst_busy_r <= 1'b0;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
                        gap_cnt_r <= gap_inc_s;
                    end
                end
                ST_RUN: begin
                    // Software request takes priority over a simultaneous watchdog expiry.
                    if (sw_rst_req) begin
                        state_r     <= ST_ASSERT;
                        hold_cnt_r  <= '0;
                        rst_n_out_r <= '0;
                        rst_busy_r  <= 1'b1;
                        rst_cause_r <= RST_CAUSE_SW;
                    end else if (wdt_expire_s) begin
                        state_r     <= ST_ASSERT;
                        hold_cnt_r  <= '0;
                        rst_n_out_r <= '0;
                        rst_busy_r  <= 1'b1;
                        rst_cause_r <= RST_CAUSE_WDT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r     <= ST_ASSERT;
                    hold_cnt_r  <= '0;
                    gap_cnt_r   <= '0;
                    rst_n_out_r <= '0;
                    rst_busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign rst_n_out = rst_n_out_r;
    assign rst_busy  = rst_busy_r;
    assign rst_cause = rst_cause_r;

endmodule

// File: tb/tb_rst_n_seq_ctrl.sv
// Bench for rst_n_seq_ctrl: an edge-count model predicts every output each
// cycle; directed literal checks pin key edges. Define RST_SEQ_WDT_EN to
// include the watchdog scenarios.
module tb_rst_n_seq_ctrl;

    localparam int S    = 2;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int N    = 3;
    localparam int WDT  = 16;

    logic         clk = 1'b0;
    logic         rst_n_async = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic         wdt_kick = 1'b0;
    logic [N-1:0] rst_n_out;
    logic         rst_busy;
    logic [1:0]   rst_cause;

    int total = 0;
    int bad   = 0;

    // Model state: edges since pad release, edge the current sequence counts from.
    int         e       = 0;
    int         base    = S;
    int         wdt_clr = 0;
    logic [1:0] cause_m = 2'b01;
    bit         kick_en = 1'b0;

    rst_n_seq_ctrl #(
        .SYNC_STAGES (S),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .NUM_CH      (N),
        .WDT_CYCLES  (WDT)
    ) dut (
        .clk         (clk),
        .rst_n_async (rst_n_async),
        .sw_rst_req  (sw_rst_req),
`ifdef RST_SEQ_WDT_EN
        .wdt_kick    (wdt_kick),
`endif
        .rst_n_out   (rst_n_out),
        .rst_busy    (rst_busy),
        .rst_cause   (rst_cause)
    );

    always #5 clk = ~clk;

    function automatic int run_edge();
        return base + HOLD + (N - 1) * GAP;
    endfunction

    function automatic logic [N-1:0] exp_out();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) begin
            v[k] = (rst_n_async === 1'b1) && (e >= base + HOLD + k * GAP);
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (edge %0d, t=%0t)", nm, act, req, e, $time);
        end
    endtask

    // Advance to the falling edge that follows model edge n.
    task automatic goto(input int n);
        int g;
        g = 0;
        while (e < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (e < n) begin
            total++;
            bad++;
            $display("FAIL goto_bound: reached edge %0d, want %0d", e, n);
        end
    endtask

    // Pad reset restarts the whole POR sequence in the model.
    always @(negedge rst_n_async) begin
        e       = 0;
        base    = S;
        cause_m = 2'b01;
        wdt_clr = 0;
    end

    // Model: count edges and apply restart rules, only while already in RUN.
    always @(posedge clk) begin
        if (rst_n_async === 1'b1) begin
            e = e + 1;
            if (e > run_edge()) begin
                if (sw_rst_req) begin
                    base    = e;
                    cause_m = 2'b10;
                end
`ifdef RST_SEQ_WDT_EN
                else if (wdt_kick) begin
                    wdt_clr = e;
                end else if (e == ((wdt_clr > run_edge()) ? wdt_clr : run_edge()) + WDT - 1) begin
                    base    = e;
                    cause_m = 2'b11;
                end
`endif
            end
        end
    end

    // Kick generator: pulse sampled on every edge that is a multiple of 10.
    always @(negedge clk) begin
        wdt_kick = kick_en && (((e + 1) % 10) == 0);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_out", rst_n_out, exp_out());
        check("model_busy", rst_busy, ~&exp_out());
        check("model_cause", rst_cause, cause_m);
    end

    initial begin
        #100000;
        $display("FAIL timeout at edge %0d", e);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n_async = 1'b0;
        repeat (3) @(negedge clk);
        check("por_held_out", rst_n_out, 3'b000);
        check("por_held_busy", rst_busy, 1'b1);
        check("por_held_cause", rst_cause, 2'b01);
        rst_n_async = 1'b1;

`ifdef RST_SEQ_WDT_EN
        goto(24); check("wdt_pre_out", rst_n_out, 3'b111);
        goto(25); check("wdt_fire_out", rst_n_out, 3'b000);
        check("wdt_fire_cause", rst_cause, 2'b11);
        goto(33); check("wdt_rerun_out", rst_n_out, 3'b111);
        kick_en = 1'b1;
        goto(100); check("wdt_kicked_out", rst_n_out, 3'b111);
        check("wdt_kicked_busy", rst_busy, 1'b0);
        kick_en = 1'b0;
        goto(114); sw_rst_req = 1'b1;
        goto(115); sw_rst_req = 1'b0;
        check("wdt_sw_tie_out", rst_n_out, 3'b000);
        check("wdt_sw_tie_cause", rst_cause, 2'b10);
        goto(123); check("wdt_sw_tie_done", rst_n_out, 3'b111);
        #1 rst_n_async = 1'b0;
        #3 rst_n_async = 1'b1;
        kick_en = 1'b1;
`endif

        goto(5);  check("por_e5", rst_n_out, 3'b000);
        goto(6);  check("por_e6", rst_n_out, 3'b001);
        check("por_e6_busy", rst_busy, 1'b1);
        goto(8);  check("por_e8", rst_n_out, 3'b011);
        goto(9);  check("por_e9", rst_n_out, 3'b011);
        goto(10); check("por_e10", rst_n_out, 3'b111);
        check("por_e10_busy", rst_busy, 1'b0);
        check("por_e10_cause", rst_cause, 2'b01);

        goto(49); sw_rst_req = 1'b1;
        goto(50); sw_rst_req = 1'b0;
        check("sw_e50", rst_n_out, 3'b000);
        check("sw_e50_busy", rst_busy, 1'b1);
        check("sw_e50_cause", rst_cause, 2'b10);
        goto(51); sw_rst_req = 1'b1;
        goto(53); check("sw_e53", rst_n_out, 3'b000);
        goto(54); check("sw_e54", rst_n_out, 3'b001);
        goto(56); check("sw_e56", rst_n_out, 3'b011);
        goto(57); sw_rst_req = 1'b0;
        goto(58); check("sw_e58", rst_n_out, 3'b111);
        check("sw_e58_busy", rst_busy, 1'b0);
        goto(62); check("sw_held_no_restart", rst_n_out, 3'b111);

        goto(79); sw_rst_req = 1'b1;
        goto(80); sw_rst_req = 1'b0;
        goto(85); check("mid_release", rst_n_out, 3'b001);
        #1 rst_n_async = 1'b0;
        #1;
        check("async_drop_out", rst_n_out, 3'b000);
        check("async_drop_busy", rst_busy, 1'b1);
        check("async_drop_cause", rst_cause, 2'b01);
        #2 rst_n_async = 1'b1;
        goto(5);  check("por2_e5", rst_n_out, 3'b000);
        goto(6);  check("por2_e6", rst_n_out, 3'b001);
        goto(8);  check("por2_e8", rst_n_out, 3'b011);
        goto(10); check("por2_e10", rst_n_out, 3'b111);
        check("por2_cause", rst_cause, 2'b01);

        goto(19); sw_rst_req = 1'b1;
        goto(28); check("held_run_e28", rst_n_out, 3'b111);
        goto(29); check("held_retrig_e29", rst_n_out, 3'b000);
        check("held_retrig_cause", rst_cause, 2'b10);
        sw_rst_req = 1'b0;
        goto(37); check("held_retrig_e37", rst_n_out, 3'b111);
        goto(45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
